mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbiter and sequencer for the single byte-wide RAM/IO port, shared by two requesters: instruction fetch (IF, always 4-byte reads) and the load/store buffer (LSB: 1/2/4-byte loads and stores).
- Serialises each request into byte transfers, assembles or splits the 32-bit data, and returns a one-cycle done pulse.
- Honours the global `rdy` stall, misprediction rollback, and the IO-buffer-full backpressure.

Parameters:
- IO_ADDR_HI, 32'h00030000, base of the IO region; stores with addr[17:16]==2'b11 are IO stores.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = freeze all state
- rollback  in  1  misprediction flush
- io_buffer_full  in  1  IO output buffer full
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction, little-endian
- lsb_req  in  1  LSB request, held until lsb_done
- lsb_we  in  1  1=store, 0=load
- lsb_len  in  2  0=1B, 1=2B, 2=4B
- lsb_addr  in  32  byte address
- lsb_wdata  in  32  store data, low bytes used
- lsb_done  out  1  one-cycle pulse
- lsb_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte (for address of previous cycle)
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1=write this cycle

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; last_grant=IF.
- States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
- IDLE arbitration, sampled on a clk edge with rdy=1:
  - If both if_req and lsb_req are high, grant the requester NOT in last_grant (round-robin). Otherwise grant whichever is high.
  - Update last_grant; latch addr, len and wdata; counter=0.
- Reads (IF_RD n=4; LS_RD n=lsb_len bytes):
  - mem_a=addr+k is driven (registered) in the k-th cycle after grant, k=0..n-1; mem_wr=0.
  - Byte k appears on mem_din one cycle after its address and is placed at data[8k+7:8k].
  - After the last byte is captured: state DONE, done=1, data registered.
  - Done latency is n+1 edges from the grant edge (IF: 5).
- Writes (LS_WR):
  - In cycle k, k=0..n-1: mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - lsb_done is visible in the cycle after the last byte, i.e. n edges after grant.
- DONE: the done output is high for exactly this one cycle. Requests are ignored here (requester drops req on seeing done). Next state is IDLE.
- Upper bytes of lsb_rdata are 0 for 1/2-byte loads.
- IO stall: in LS_WR, if the store is an IO store and io_buffer_full=1, then mem_wr=0, the counter holds, and the byte is retried while io_buffer_full stays high.
- rdy=0: all registers hold; mem_wr forced 0. Resume with no lost bytes.
- rollback=1:
  - IF_RD or LS_RD: abort; go to IDLE with no done pulse; mem_wr=0.
  - LS_WR: completes normally (committed store).
  - DONE for IF or load: done is suppressed.
  - IDLE: no grant is made that cycle.
- Address arithmetic is 32-bit wrap-around; no alignment checks.
- rst mid-transfer: immediate IDLE, all outputs 0, no done.

Test Plan:
- IF read addr 0x100, RAM bytes 13,05,00,00 -> mem_a 0x100..0x103 on consecutive cycles; if_done pulse 5 edges after grant; if_data=0x00000513.
- LSB store len=2, addr 0x200, wdata 0xDEADBEEF -> two cycles of mem_wr=1: (0x200,EF),(0x201,BE); lsb_done after 2 edges; RAM 0x202 untouched.
- if_req and lsb_req both high from reset -> LSB is served first (last_grant=IF). IF is served next even though lsb_req is re-raised in the DONE cycle.
- LSB 1-byte load of 0x80 -> lsb_rdata=0x00000080.
- IF read in progress; rollback asserted at byte 2 -> no if_done; IDLE next cycle. The same test during a 4-byte store -> all 4 bytes written, lsb_done pulses.
- IO store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr=0 for 3 cycles, then one write; lsb_done follows. rdy low for 2 cycles mid-read -> identical data, done delayed 2 cycles.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte sequencer for the shared 8-bit RAM/IO port.
// Instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte
// loads and stores) take turns round-robin; each request is split into byte
// transfers and answered with a one-cycle done pulse.
module mem_ctrl #(
    parameter logic [31:0] IO_ADDR_HI = 32'h00030000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_IF_RD = 3'd1;
    localparam logic [2:0] S_LS_RD = 3'd2;
    localparam logic [2:0] S_LS_WR = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Byte count for an LSB length code; code 3 is treated as a word.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic        last_lsb;
    logic        cur_lsb;
    logic        cur_we;
    logic [31:0] base_addr;
    logic [31:0] wdata_q;
    logic [31:0] data_buf;
    logic [31:0] if_data_q;
    logic [31:0] lsb_rdata_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic [7:0]  din_hold;
    logic        use_hold;
    logic        wr_q;
    logic        if_done_q;
    logic        lsb_done_q;

    logic [7:0]  din_eff;
    logic [2:0]  cnt_nxt;
    logic [31:0] merged;
    logic        io_stall;
    logic        grant_lsb;
    logic        grant_any;
    logic [31:0] grant_addr;

    // While frozen the RAM keeps answering the held address, so the byte
    // that was on mem_din when the freeze began is parked and used on resume.
    always_comb begin
        din_eff = use_hold ? din_hold : mem_din;
        cnt_nxt = cnt + 3'd1;
    end

    // Read assembly: cycle k (k>=1) carries byte k-1 of the transfer.
    always_comb begin
        merged = data_buf;
        case (cnt)
            3'd1:    merged[7:0]   = din_eff;
            3'd2:    merged[15:8]  = din_eff;
            3'd3:    merged[23:16] = din_eff;
            3'd4:    merged[31:24] = din_eff;
            default: merged = data_buf;
        endcase
    end

    // Round-robin grant and IO backpressure detection.
    always_comb begin
        io_stall   = (state == S_LS_WR) &&
                     (base_addr[17:16] == IO_ADDR_HI[17:16]) && io_buffer_full;
        grant_lsb  = lsb_req && (!if_req || !last_lsb);
        grant_any  = (if_req || lsb_req) && !rollback;
        grant_addr = grant_lsb ? lsb_addr : if_addr;
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = wr_q && rdy && !io_stall;
    assign if_done   = if_done_q && rdy && !rollback;
    assign lsb_done  = lsb_done_q && rdy && !(rollback && !cur_we);
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

    // Sequencer: grant, per-byte address/data stepping, done generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 3'd0;
            n_bytes     <= 3'd0;
            last_lsb    <= 1'b0;
            cur_lsb     <= 1'b0;
            cur_we      <= 1'b0;
            base_addr   <= 32'd0;
            wdata_q     <= 32'd0;
            data_buf    <= 32'd0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            din_hold    <= 8'd0;
            use_hold    <= 1'b0;
            wr_q        <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
        end else if (rdy) begin
            use_hold   <= 1'b0;
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        state      <= grant_lsb ? (lsb_we ? S_LS_WR : S_LS_RD) : S_IF_RD;
                        last_lsb   <= grant_lsb;
                        cur_lsb    <= grant_lsb;
                        cur_we     <= grant_lsb && lsb_we;
                        base_addr  <= grant_addr;
                        mem_a_q    <= grant_addr;
                        n_bytes    <= grant_lsb ? len_to_bytes(lsb_len) : 3'd4;
                        wdata_q    <= lsb_wdata;
                        mem_dout_q <= lsb_wdata[7:0];
                        wr_q       <= grant_lsb && lsb_we;
                        cnt        <= 3'd0;
                        data_buf   <= 32'd0;
                    end
                end
                S_IF_RD, S_LS_RD: begin
                    if (rollback) begin
                        state <= S_IDLE;
                    end else begin
                        data_buf <= merged;
                        if (cnt == n_bytes) begin
                            state <= S_DONE;
                            if (cur_lsb) begin
                                lsb_done_q  <= 1'b1;
                                lsb_rdata_q <= merged;
                            end else begin
                                if_done_q <= 1'b1;
                                if_data_q <= merged;
                            end
                        end else begin
                            cnt <= cnt_nxt;
                            if (cnt_nxt < n_bytes)
                                mem_a_q <= base_addr + {29'd0, cnt_nxt};
                        end
                    end
                end
                S_LS_WR: begin
                    if (!io_stall) begin
                        if (cnt == n_bytes - 3'd1) begin
                            state      <= S_DONE;
                            wr_q       <= 1'b0;
                            lsb_done_q <= 1'b1;
                        end else begin
                            cnt        <= cnt_nxt;
                            mem_a_q    <= base_addr + {29'd0, cnt_nxt};
                            mem_dout_q <= wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end else begin
            if (!use_hold) begin
                din_hold <= mem_din;
                use_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, io_buffer_full;
    logic        if_req, if_done, lsb_req, lsb_we, lsb_done, mem_wr;
    logic [31:0] if_addr, if_data, lsb_addr, lsb_wdata, lsb_rdata, mem_a;
    logic [1:0]  lsb_len;
    logic [7:0]  mem_din, mem_dout;

    int errors = 0;
    int checks = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM model: registered read of the current address, write log.
    logic [7:0]  ram [0:4095];
    logic [31:0] wlog_a [0:15];
    logic [7:0]  wlog_d [0:15];
    int          wcount = 0;
    int          if_done_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h55;
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
            ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h00;
            ram[12'h300] <= 8'h80;
            ram[12'h304] <= 8'h34; ram[12'h305] <= 8'h12;
            ram[12'h308] <= 8'h78; ram[12'h309] <= 8'h56;
            ram[12'h30A] <= 8'h34; ram[12'h30B] <= 8'h12;
            ram[12'h30D] <= 8'hAB; ram[12'h30E] <= 8'hCD;
            ram[12'hFFE] <= 8'h11; ram[12'hFFF] <= 8'h22;
            ram[12'h000] <= 8'h33; ram[12'h001] <= 8'h44;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wlog_a[wcount[3:0]] <= mem_a;
            wlog_d[wcount[3:0]] <= mem_dout;
            wcount <= wcount + 1;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    always @(negedge clk) begin
        if (if_done) if_done_cnt <= if_done_cnt + 1;
    end

    typedef struct {
        string       name;
        logic        lsb;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mkv(input string nm, input logic lsb, input logic we,
                                 input logic [1:0] len, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] ed,
                                 input int lat);
        vec_t v;
        v.name = nm; v.lsb = lsb; v.we = we; v.len = len; v.addr = addr;
        v.wdata = wd; v.exp_data = ed; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic wlog_ok(input int base, input int n,
                                     input logic [31:0] addr, input logic [31:0] wd);
        if (wcount - base != n) return 1'b0;
        for (int k = 0; k < n; k++) begin
            if (wlog_a[(base + k) % 16] !== addr + 32'(k)) return 1'b0;
            if (wlog_d[(base + k) % 16] !== wd[8*k +: 8]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One transaction; m counts edges after the grant edge (grant edge = 0).
    task automatic run_txn(input vec_t v, input int rb_at, input int rdy_at,
                           input int rdy_len, input int io_at, input int io_len,
                           output int lat, output logic [31:0] data,
                           output logic seq_ok, output int nwr);
        int   n;
        int   m;
        logic seen;
        n = v.lsb ? ((v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4) : 4;
        seq_ok = 1'b1; nwr = 0; lat = -1; data = 32'd0; seen = 1'b0;
        if (v.lsb) begin
            lsb_req = 1'b1; lsb_we = v.we; lsb_len = v.len;
            lsb_addr = v.addr; lsb_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        m = -1;
        while (!seen && m < 60) begin
            @(posedge clk); #1;
            m++;
            rollback       = (m == rb_at);
            rdy            = !(m >= rdy_at && m < rdy_at + rdy_len);
            io_buffer_full = (m >= io_at && m < io_at + io_len);
            #1;
            if (m < n && (mem_a !== v.addr + 32'(m) || mem_wr !== v.we)) seq_ok = 1'b0;
            if (mem_wr === 1'b1) nwr++;
            if (v.lsb ? lsb_done : if_done) begin
                seen = 1'b1;
                lat  = m;
                data = v.lsb ? lsb_rdata : if_data;
            end
        end
        rollback = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b0; lsb_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output logic [1:0] w, output logic [31:0] idata,
                             output logic [31:0] ldata);
        w = 2'b00;
        for (int i = 0; i < 40 && w == 2'b00; i++) begin
            @(posedge clk); #2;
            w = {lsb_done, if_done};
        end
        idata = if_data;
        ldata = lsb_rdata;
    endtask

    vec_t        vt [0:8];
    int          lat, nwr, wbase, base_cnt;
    logic [31:0] data, idata, ldata;
    logic        sq;
    logic [1:0]  w;

    initial begin
        vt[0] = mkv("if_100",  1'b0, 1'b0, 2'd2, 32'h00000100, 32'h0,        32'h00000513, 5);
        vt[1] = mkv("st2_200", 1'b1, 1'b1, 2'd1, 32'h00000200, 32'hDEADBEEF, 32'h0,        2);
        vt[2] = mkv("ld1_300", 1'b1, 1'b0, 2'd0, 32'h00000300, 32'h0,        32'h00000080, 2);
        vt[3] = mkv("ld2_304", 1'b1, 1'b0, 2'd1, 32'h00000304, 32'h0,        32'h00001234, 3);
        vt[4] = mkv("ld4_308", 1'b1, 1'b0, 2'd2, 32'h00000308, 32'h0,        32'h12345678, 5);
        vt[5] = mkv("st4_400", 1'b1, 1'b1, 2'd2, 32'h00000400, 32'hA1B2C3D4, 32'h0,        4);
        vt[6] = mkv("ld4_400", 1'b1, 1'b0, 2'd2, 32'h00000400, 32'h0,        32'hA1B2C3D4, 5);
        vt[7] = mkv("if_wrap", 1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        32'h44332211, 5);
        vt[8] = mkv("ld2_30d", 1'b1, 1'b0, 2'd1, 32'h0000030D, 32'h0,        32'h0000CDAB, 3);

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_len = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_wr_dout", {23'd0, mem_wr, mem_dout}, 32'd0);
        chk("rst_done", {30'd0, if_done, lsb_done}, 32'd0);
        chk("rst_data", if_data | lsb_rdata, 32'd0);

        // Both requesters from reset: LSB first, then IF, then LSB again.
        if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h300;
        wait_done(w, idata, ldata);
        chk("arb1_who", 32'(w), 32'd2);
        chk("arb1_data", ldata, 32'h80);
        lsb_addr = 32'h30D; lsb_len = 2'd1;
        wait_done(w, idata, ldata);
        chk("arb2_who", 32'(w), 32'd1);
        chk("arb2_data", idata, 32'h513);
        if_req = 1'b0;
        wait_done(w, idata, ldata);
        chk("arb3_who", 32'(w), 32'd2);
        chk("arb3_data", ldata, 32'h0000CDAB);
        lsb_req = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            wbase = wcount;
            run_txn(vt[i], -1, -1, 0, -1, 0, lat, data, sq, nwr);
            chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].exp_lat));
            chk({vt[i].name, "_seq"}, 32'(sq), 32'd1);
            if (vt[i].we)
                chk({vt[i].name, "_writes"},
                    32'(wlog_ok(wbase, (vt[i].len == 2'd1) ? 2 : 4, vt[i].addr, vt[i].wdata)),
                    32'd1);
            else
                chk({vt[i].name, "_data"}, data, vt[i].exp_data);
        end
        chk("ram_202_untouched", 32'(ram[12'h202]), 32'h55);

        // Rollback at byte 2 of a fetch: abort, no done, IDLE right after.
        base_cnt = if_done_cnt;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) begin @(posedge clk); #1; end
        chk("rb_if_addr", mem_a, 32'h102);
        rollback = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        rollback = 1'b0;
        run_txn(vt[2], -1, -1, 0, -1, 0, lat, data, sq, nwr);
        chk("rb_if_next_lat", 32'(lat), 32'd2);
        chk("rb_if_next_data", data, 32'h80);
        chk("rb_if_nodone", 32'(if_done_cnt - base_cnt), 32'd0);

        // Rollback during a word store: store completes.
        wbase = wcount;
        run_txn(mkv("rb_st", 1'b1, 1'b1, 2'd2, 32'h500, 32'h11223344, 32'h0, 4),
                2, -1, 0, -1, 0, lat, data, sq, nwr);
        chk("rb_st_lat", 32'(lat), 32'd4);
        chk("rb_st_writes", 32'(wlog_ok(wbase, 4, 32'h500, 32'h11223344)), 32'd1);

        // IO store held off by a full IO buffer for three cycles.
        wbase = wcount;
        run_txn(mkv("io_st", 1'b1, 1'b1, 2'd0, 32'h00030000, 32'h0000005A, 32'h0, 4),
                -1, -1, 0, 0, 3, lat, data, sq, nwr);
        chk("io_st_lat", 32'(lat), 32'd4);
        chk("io_st_nwr", 32'(nwr), 32'd1);
        chk("io_st_writes", 32'(wlog_ok(wbase, 1, 32'h00030000, 32'h5A)), 32'd1);

        // rdy low for two cycles mid-fetch and mid-store.
        run_txn(vt[0], -1, 2, 2, -1, 0, lat, data, sq, nwr);
        chk("rdy_rd_lat", 32'(lat), 32'd7);
        chk("rdy_rd_data", data, 32'h513);
        wbase = wcount;
        run_txn(mkv("rdy_st", 1'b1, 1'b1, 2'd2, 32'h600, 32'hCAFEF00D, 32'h0, 6),
                -1, 1, 2, -1, 0, lat, data, sq, nwr);
        chk("rdy_st_lat", 32'(lat), 32'd6);
        chk("rdy_st_nwr", 32'(nwr), 32'd4);
        chk("rdy_st_writes", 32'(wlog_ok(wbase, 4, 32'h600, 32'hCAFEF00D)), 32'd1);

        // Reset in the middle of a fetch.
        base_cnt = if_done_cnt;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0;
        #1;
        chk("mrst_mem_a", mem_a, 32'd0);
        chk("mrst_wr", 32'(mem_wr), 32'd0);
        chk("mrst_data", if_data | lsb_rdata, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("mrst_nodone", 32'(if_done_cnt - base_cnt), 32'd0);
        run_txn(vt[2], -1, -1, 0, -1, 0, lat, data, sq, nwr);
        chk("mrst_next_lat", 32'(lat), 32'd2);
        chk("mrst_next_data", data, 32'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
